// File: rtl/mux_parametros_sync_if.sv
// Bundle of the user/RTC/VGA/write-sequencer signals around the parameter selector.
// The slave modport is the selector itself; the master modport is whoever drives it.
interface mux_parametros_sync_if #(
    parameter int NUM_FIELDS = 9,
    parameter int FIELD_W    = 8
);
    localparam int BUS_W = NUM_FIELDS * FIELD_W;

    logic [BUS_W-1:0] usr_bus;
    logic [BUS_W-1:0] rtc_bus;
    logic             rtc_valid;
    logic             edit_pulse;
    logic             commit;
    logic             frame_tick;
    logic             wr_ack;
    logic [BUS_W-1:0] vga_bus;
    logic [BUS_W-1:0] wr_data;
    logic             wr_req;
    logic             src_usr;
    logic             vga_upd;

    modport slave (
        input  usr_bus, rtc_bus, rtc_valid, edit_pulse, commit, frame_tick, wr_ack,
        output vga_bus, wr_data, wr_req, src_usr, vga_upd
    );

    modport master (
        output usr_bus, rtc_bus, rtc_valid, edit_pulse, commit, frame_tick, wr_ack,
        input  vga_bus, wr_data, wr_req, src_usr, vga_upd
    );
endinterface

// File: rtl/mux_parametros_sync.sv
// Selects RTC or user-entered date/time fields for the VGA overlay, reloading the
// display only on frame ticks, and hands committed edits to the RTC write sequencer.
module mux_parametros_sync #(
    parameter int NUM_FIELDS  = 9,
    parameter int FIELD_W     = 8,
    parameter int TIMEOUT_CYC = 1000000,
    localparam int CNT_W      = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mux_parametros_sync_if.slave   bus
);
    localparam int BUS_W = NUM_FIELDS * FIELD_W;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_RTC    = 2'd0,
        S_EDIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BUS_W-1:0] shadow_q;
    logic [BUS_W-1:0] vga_q;
    logic [BUS_W-1:0] wr_data_q;
    logic             wr_req_q;
    logic             src_usr_q;
    logic             vga_upd_q;
    logic [BUS_W-1:0] disp_d;

    // A fresh RTC read arriving with the frame tick bypasses the shadow so the
    // display never lags the shadow by a whole frame.
    always_comb begin
        disp_d = shadow_q;
        unique case (state_q)
            S_RTC:    disp_d = bus.rtc_valid ? bus.rtc_bus : shadow_q;
            S_EDIT:   disp_d = bus.usr_bus;
            S_COMMIT: disp_d = wr_data_q;
            default:  disp_d = shadow_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_RTC;
            cnt_q     <= '0;
            shadow_q  <= '0;
            vga_q     <= '0;
            wr_data_q <= '0;
            wr_req_q  <= 1'b0;
            src_usr_q <= 1'b0;
            vga_upd_q <= 1'b0;
        end else begin
            if (bus.rtc_valid) begin
                shadow_q <= bus.rtc_bus;
            end

            vga_upd_q <= bus.frame_tick;
            if (bus.frame_tick) begin
                vga_q <= disp_d;
            end

            // src_usr is written alongside every state change so it tracks the state register.
            unique case (state_q)
                S_RTC: begin
                    if (bus.edit_pulse) begin
                        state_q   <= S_EDIT;
                        src_usr_q <= 1'b1;
                        cnt_q     <= CNT_RELOAD;
                    end
                end
                S_EDIT: begin
                    if (bus.commit) begin
                        state_q   <= S_COMMIT;
                        wr_data_q <= bus.usr_bus;
                        wr_req_q  <= 1'b1;
                    end else if (bus.edit_pulse) begin
                        cnt_q <= CNT_RELOAD;
                    end else if (cnt_q == '0) begin
                        state_q   <= S_RTC;
                        src_usr_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_COMMIT: begin
                    if (bus.wr_ack) begin
                        wr_req_q  <= 1'b0;
                        state_q   <= S_RTC;
                        src_usr_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_RTC;
                    src_usr_q <= 1'b0;
                    wr_req_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vga_bus = vga_q;
    assign bus.wr_data = wr_data_q;
    assign bus.wr_req  = wr_req_q;
    assign bus.src_usr = src_usr_q;
    assign bus.vga_upd = vga_upd_q;
endmodule

// File: tb/tb_mux_parametros_sync.sv
// Table-driven bench for mux_parametros_sync with a scoreboard of expected
// display words checked whenever vga_upd reports a reload.
module tb_mux_parametros_sync;
    localparam int NF = 9;
    localparam int FW = 8;
    localparam int BW = NF * FW;
    localparam int TO = 8;

    typedef logic [BW-1:0] word_t;

    typedef struct {
        string name;
        logic  rv;
        word_t rb;
        logic  ep;
        logic  cm;
        logic  ft;
        word_t ub;
        logic  ack;
        word_t exp_vga;
        logic  exp_req;
        logic  exp_src;
        word_t exp_wd;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    vec_t vecs[$];
    word_t sb_q[$];

    mux_parametros_sync_if #(.NUM_FIELDS(NF), .FIELD_W(FW)) bus_if ();

    mux_parametros_sync #(
        .NUM_FIELDS (NF),
        .FIELD_W    (FW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    function automatic word_t fld(input int idx, input logic [7:0] v);
        word_t r;
        r = '0;
        r[idx*FW +: FW] = v;
        return r;
    endfunction

    task automatic chk(input string name, input word_t act, input word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic rv, input word_t rb, input logic ep,
                       input logic cm, input logic ft, input word_t ub, input logic ack,
                       input word_t ev, input logic er, input logic es, input word_t ew);
        vec_t v;
        v.name = name; v.rv = rv; v.rb = rb; v.ep = ep; v.cm = cm; v.ft = ft;
        v.ub = ub; v.ack = ack; v.exp_vga = ev; v.exp_req = er; v.exp_src = es; v.exp_wd = ew;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        bus_if.rtc_valid  = 1'b0;
        bus_if.rtc_bus    = '0;
        bus_if.edit_pulse = 1'b0;
        bus_if.commit     = 1'b0;
        bus_if.frame_tick = 1'b0;
        bus_if.wr_ack     = 1'b0;
    endtask

    // Scoreboard consumer: every vga_upd pulse must match the oldest expected reload.
    always @(negedge clk) begin
        if (reset_n && bus_if.vga_upd) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected_upd: got vga_upd=1 with vga %h expected no update", bus_if.vga_bus);
            end else begin
                chk("sb_vga_upd", bus_if.vga_bus, sb_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        word_t z, r1, r2, u1, u1b, u2, u3;
        z   = '0;
        r1  = fld(0, 8'h16) | fld(8, 8'h59);
        r2  = r1 | fld(3, 8'h23);
        u1  = fld(4, 8'h30);
        u1b = fld(4, 8'h31);
        u2  = fld(5, 8'h45);
        u3  = fld(2, 8'h12);

        //   name            rv rb  ep cm ft ub   ack  vga  req src wd
        add("rtc_load",      1, r1, 0, 0, 0, z,   0,   z,   0,  0,  z);
        add("no_tick_hold",  0, z,  0, 0, 0, z,   0,   z,   0,  0,  z);
        add("tick_rtc",      0, z,  0, 0, 1, z,   0,   r1,  0,  0,  z);
        add("idle",          0, z,  0, 0, 0, z,   0,   r1,  0,  0,  z);
        add("bypass",        1, r2, 0, 0, 1, z,   0,   r2,  0,  0,  z);
        add("ack_no_req",    0, z,  0, 0, 0, z,   1,   r2,  0,  0,  z);
        add("commit_in_rtc", 0, z,  0, 1, 0, z,   0,   r2,  0,  0,  z);
        add("edit_enter",    0, z,  1, 0, 0, u1,  0,   r2,  0,  1,  z);
        add("edit_tick",     0, z,  0, 0, 1, u1,  0,   u1,  0,  1,  z);
        for (int i = 2; i < TO; i++)
            add($sformatf("edit_wait%0d", i), 0, z, 0, 0, 0, u1, 0, u1, 0, 1, z);
        add("timeout_tick",  0, z,  0, 0, 1, u1b, 0,   u1b, 0,  0,  z);
        add("rtc_tick",      0, z,  0, 0, 1, u1b, 0,   r2,  0,  0,  z);
        add("edit2",         0, z,  1, 0, 0, z,   0,   r2,  0,  1,  z);
        add("commit",        0, z,  0, 1, 0, u2,  0,   r2,  1,  1,  u2);
        add("hold_tick",     0, z,  0, 0, 1, z,   0,   u2,  1,  1,  u2);
        add("hold_ignore",   0, z,  1, 1, 0, z,   0,   u2,  1,  1,  u2);
        add("hold3",         0, z,  0, 0, 0, z,   0,   u2,  1,  1,  u2);
        add("hold4",         0, z,  0, 0, 0, z,   0,   u2,  1,  1,  u2);
        add("ack",           0, z,  0, 0, 0, z,   1,   u2,  0,  0,  u2);
        add("post_ack_tick", 0, z,  0, 0, 1, z,   0,   r2,  0,  0,  u2);
        add("edit3",         0, z,  1, 0, 0, u3,  0,   r2,  0,  1,  u2);
        add("commit_edit",   0, z,  1, 1, 0, u3,  0,   r2,  1,  1,  u3);
        add("ack_first",     0, z,  0, 0, 0, u3,  1,   r2,  0,  0,  u3);
        add("post_ack_idle", 0, z,  0, 0, 0, u3,  0,   r2,  0,  0,  u3);
        add("edit4",         0, z,  1, 0, 0, u2,  0,   r2,  0,  1,  u3);
        add("commit4",       0, z,  0, 1, 0, u2,  0,   r2,  1,  1,  u2);

        drive_idle();
        bus_if.usr_bus = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vga", bus_if.vga_bus, z);
        chk("rst_wr_req", word_t'(bus_if.wr_req), z);
        chk("rst_src_usr", word_t'(bus_if.src_usr), z);
        chk("rst_vga_upd", word_t'(bus_if.vga_upd), z);
        chk("rst_wr_data", bus_if.wr_data, z);
        reset_n = 1'b1;

        foreach (vecs[k]) begin
            bus_if.rtc_valid  = vecs[k].rv;
            bus_if.rtc_bus    = vecs[k].rb;
            bus_if.edit_pulse = vecs[k].ep;
            bus_if.commit     = vecs[k].cm;
            bus_if.frame_tick = vecs[k].ft;
            bus_if.usr_bus    = vecs[k].ub;
            bus_if.wr_ack     = vecs[k].ack;
            if (vecs[k].ft) sb_q.push_back(vecs[k].exp_vga);
            @(posedge clk);
            #1;
            chk({vecs[k].name, "_vga"}, bus_if.vga_bus, vecs[k].exp_vga);
            chk({vecs[k].name, "_req"}, word_t'(bus_if.wr_req), word_t'(vecs[k].exp_req));
            chk({vecs[k].name, "_src"}, word_t'(bus_if.src_usr), word_t'(vecs[k].exp_src));
            chk({vecs[k].name, "_wd"}, bus_if.wr_data, vecs[k].exp_wd);
        end

        // Asynchronous reset while a write is pending: outputs clear between clock edges.
        drive_idle();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_req", word_t'(bus_if.wr_req), z);
        chk("async_rst_src", word_t'(bus_if.src_usr), z);
        chk("async_rst_vga", bus_if.vga_bus, z);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_req%0d", i), word_t'(bus_if.wr_req), z);
            chk($sformatf("post_rst_src%0d", i), word_t'(bus_if.src_usr), z);
        end

        @(posedge clk);
        #1;
        chk("sb_drained", word_t'(sb_q.size()), z);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_parametros_sync.md
Name: mux_parametros_sync

Overview:
Parametrised, registered successor to the user/RTC parameter selector feeding the VGA text overlay. It holds a coherent shadow copy of the date/time/timer fields read from the RTC. It runs an edit/commit state machine that decides whether the display shows RTC values or user-entered values. The VGA output bus updates only on frame boundaries, so digits never tear mid-frame. It also issues a write request/acknowledge handshake to the RTC write sequencer when the user commits edited values.

Parameters:
NUM_FIELDS, 9, number of parameter fields (year, month, day, h, m, s, timer h/m/s by default)
FIELD_W, 8, width of each field in bits (BCD byte by default)
TIMEOUT_CYC, 1000000, clk cycles of edit inactivity before edit mode is abandoned; must be >= 2
CNT_W, $clog2(TIMEOUT_CYC+1), timeout counter width (derived, not overridden)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
usr_bus  in  NUM_FIELDS*FIELD_W  user-entered fields, field 0 in the LSBs
rtc_bus  in  NUM_FIELDS*FIELD_W  fields read from RTC, valid only when rtc_valid=1
rtc_valid  in  1  one-cycle pulse: rtc_bus holds a complete, coherent read
edit_pulse  in  1  one-cycle pulse per user keypress/adjustment
commit  in  1  one-cycle pulse: user confirms edited values
frame_tick  in  1  one-cycle pulse at start of VGA vertical blanking
wr_ack  in  1  RTC write sequencer accepted the write
vga_bus  out  NUM_FIELDS*FIELD_W  registered fields to VGA
wr_data  out  NUM_FIELDS*FIELD_W  usr_bus captured at commit, stable while wr_req=1
wr_req  out  1  write request to RTC write sequencer
src_usr  out  1  1 = display source is user values (EDIT or COMMIT state)
vga_upd  out  1  one-cycle pulse, asserted the cycle after vga_bus is reloaded

Behaviour:
- Reset (async, reset_n=0): state=S_RTC; rtc_shadow=0, vga_bus=0, wr_data=0, wr_req=0, src_usr=0, vga_upd=0, timeout counter=0. Release takes effect on the next clk edge.
- Shadow: on rtc_valid, rtc_shadow <= rtc_bus, all fields in the same edge. It updates in every state.
- States:
  - S_RTC: display source is rtc_shadow. edit_pulse -> S_EDIT, counter <= TIMEOUT_CYC-1. commit is ignored.
  - S_EDIT: display source is usr_bus.
    - commit -> S_COMMIT, wr_data <= usr_bus, wr_req <= 1. commit has priority over edit_pulse in the same cycle.
    - else edit_pulse -> counter reloads to TIMEOUT_CYC-1.
    - else counter==0 -> S_RTC (timeout, no write).
    - else counter decrements.
  - S_COMMIT: display source is wr_data (frozen).
    - wr_req stays high until wr_ack is sampled high.
    - On wr_ack: wr_req <= 0, state -> S_RTC.
    - edit_pulse and commit are ignored. There is no timeout in this state.
- wr_ack while wr_req=0 is ignored. wr_ack may arrive in the first cycle wr_req is high.
- src_usr is registered: 1 in S_EDIT and S_COMMIT, 0 in S_RTC, following the state register with no extra delay.
- Display update: on frame_tick, vga_bus <= the source for the current state. vga_upd is 1 the next cycle. Without frame_tick, vga_bus holds.
- frame_tick and rtc_valid in the same cycle while in S_RTC: vga_bus <= rtc_bus directly (bypass), so vga_bus equals the new shadow.
- frame_tick on the same edge as a state transition: the source is chosen by the pre-transition state.
- Latency: an input change is visible on vga_bus at most one frame period plus 1 cycle later.
- Fields are passed through untouched; the block does no BCD checking or arithmetic.
- Reset asserted mid-commit: wr_req drops immediately (async) and no write is reissued.

Test Plan:
- Reset, then rtc_valid with rtc_bus field0=0x16, field8=0x59, no frame_tick -> vga_bus stays 0. Next frame_tick -> vga_bus field0=0x16, field8=0x59; vga_upd pulses 1 cycle later; src_usr=0.
- frame_tick and rtc_valid (field3=0x23) in the same cycle in S_RTC -> vga_bus field3=0x23 on that edge (bypass check).
- edit_pulse, usr_bus field4=0x30, frame_tick -> src_usr=1, vga_bus field4=0x30. With TIMEOUT_CYC=8 and no further pulses -> return to S_RTC exactly 8 cycles after edit_pulse; next frame_tick shows rtc_shadow.
- In S_EDIT, commit with usr_bus field5=0x45; change usr_bus to 0x00; hold wr_ack low 5 cycles -> wr_req high 5 cycles, wr_data field5=0x45 stable, vga_bus on frame_tick shows 0x45. Then wr_ack=1 -> wr_req=0 next edge, src_usr=0.
- commit and edit_pulse in the same cycle in S_EDIT -> S_COMMIT is entered. commit in S_RTC -> no wr_req.
- reset_n pulsed low while wr_req=1 -> wr_req, vga_bus and src_usr go to 0 without waiting for a clk edge; no wr_req after release.
